// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types, constants and divisor helper (rx and tx).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_state_e;

   // Sysclk cycles per sample tick, rounded to nearest.
   function automatic int calc_div(input int clk, input int baud, input int os);
      longint unsigned den;
      den = longint'(baud) * longint'(os);
      return int'((longint'(clk) + den / 2) / den);
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module   : uart_baud_tick
// Brief    : Free-running divide-by-DIV tick generator with synchronous restart.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
   parameter int DIV = 651
) (
   input  logic sysclk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (restart || (cnt_q == LAST)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // A restart cycle never emits a tick, so the bit timing starts cleanly.
   assign tick = (cnt_q == LAST) && !restart;

endmodule

`default_nettype wire

// File: rtl/uart_rx_frontend.sv
// ============================================================================
// Module   : uart_rx_frontend
// Brief    : 16x-oversampled 8N1 UART receiver with sticky status flags.
//            Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frontend
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic                 sysclk,
   input  logic                 reset,
   input  logic                 uart_rx,
   input  logic                 rx_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 parity_err
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int OCW = $clog2(OVERSAMPLE);

   localparam logic [OCW-1:0] T_S0   = OCW'(OVERSAMPLE / 2 - 1);
   localparam logic [OCW-1:0] T_S1   = OCW'(OVERSAMPLE / 2);
   localparam logic [OCW-1:0] T_RES  = OCW'(OVERSAMPLE / 2 + 1);
   localparam logic [OCW-1:0] T_LAST = OCW'(OVERSAMPLE - 1);

   logic                 sync1_q;
   logic                 rxs_q;
   logic                 rxs_prev_q;
   uart_state_e          state_q;
   logic [OCW-1:0]       os_cnt_q;
   logic [2:0]           bit_cnt_q;
   logic                 smp0_q;
   logic                 smp1_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 commit_q;
   logic [DATA_BITS-1:0] rx_data_q;
   logic                 rx_valid_q;
   logic                 frame_err_q;
   logic                 overrun_q;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad_q;
   logic                 parity_err_q;
`endif

   logic tick;
   logic start_edge;
   logic bit_val;
   logic at_res;
   logic at_last;

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         sync1_q    <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
      end else begin
         sync1_q    <= uart_rx;
         rxs_q      <= sync1_q;
         rxs_prev_q <= rxs_q;
      end
   end

   assign start_edge = (state_q == IDLE) && rxs_prev_q && !rxs_q;

   uart_baud_tick #(
      .DIV (DIV)
   ) u_tick (
      .sysclk  (sysclk),
      .reset   (reset),
      .restart (start_edge),
      .tick    (tick)
   );

   // Third vote is the live sample taken on the resolving tick itself.
   assign bit_val = (smp0_q & smp1_q) | (smp0_q & rxs_q) | (smp1_q & rxs_q);
   assign at_res  = tick && (os_cnt_q == T_RES);
   assign at_last = tick && (os_cnt_q == T_LAST);

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         os_cnt_q     <= '0;
         bit_cnt_q    <= '0;
         smp0_q       <= 1'b1;
         smp1_q       <= 1'b1;
         shift_q      <= '0;
         commit_q     <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         commit_q <= 1'b0;

         if (tick) begin
            os_cnt_q <= (os_cnt_q == T_LAST) ? '0 : os_cnt_q + 1'b1;
            if (os_cnt_q == T_S0) smp0_q <= rxs_q;
            if (os_cnt_q == T_S1) smp1_q <= rxs_q;
         end

         if (rx_ack) begin
            rx_valid_q   <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
         end

         case (state_q)
            IDLE: begin
               if (start_edge) begin
                  state_q   <= START;
                  os_cnt_q  <= '0;
                  bit_cnt_q <= '0;
               end
            end
            START: begin
               if (at_res && bit_val) begin
                  state_q <= IDLE;
               end else if (at_last) begin
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (at_res) begin
                  shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
               end
               if (at_last) begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (at_res) begin
                  par_bad_q <= ((^shift_q) ^ bit_val) != PARITY_ODD;
               end
               if (at_last) begin
                  state_q <= STOP;
               end
            end
`endif
            STOP: begin
               // Leave mid stop bit so the next start edge is not missed.
               if (at_res) begin
                  if (bit_val) begin
                     commit_q <= 1'b1;
                     state_q  <= IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= BREAK;
                  end
               end
            end
            BREAK: begin
               if (rxs_q) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         // Commit overrides a simultaneous acknowledge.
         if (commit_q) begin
            rx_data_q  <= shift_q;
            rx_valid_q <= 1'b1;
            if (rx_valid_q && !rx_ack) begin
               overrun_q <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
               parity_err_q <= 1'b1;
            end
`endif
         end
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
// ============================================================================
// Module   : tb_uart_rx_frontend
// Brief    : Scoreboard bench for uart_rx_frontend at a fast line rate (DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_frontend;

   localparam int CLK_FREQ = 100000000;
   localparam int BAUD     = 1562500;
   localparam int OS       = 16;
   localparam int DIV      = 4;            // 100e6 / (1.5625e6 * 16)
   localparam int BIT_CYC  = DIV * OS;

   logic       sysclk = 1'b0;
   logic       reset  = 1'b1;
   logic       uart_rx = 1'b1;
   logic       rx_ack = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
   } exp_t;

   exp_t sb_q[$];

   always #5 sysclk = ~sysclk;

   uart_rx_frontend #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OS)
`ifdef UART_RX_PARITY_EN
      ,
      .PARITY_ODD (1'b0)
`endif
   ) dut (
      .sysclk     (sysclk),
      .reset      (reset),
      .uart_rx    (uart_rx),
      .rx_ack     (rx_ack),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [7:0] d, input logic perr);
      exp_t e;
      e.data = d;
      e.perr = perr;
      sb_q.push_back(e);
   endtask

   // par_flip inverts the even-parity bit when parity is compiled in.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
      @(negedge sysclk);
      uart_rx = 1'b0;
      repeat (BIT_CYC) @(negedge sysclk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = d[i];
         repeat (BIT_CYC) @(negedge sysclk);
      end
`ifdef UART_RX_PARITY_EN
      uart_rx = (^d) ^ par_flip;
      repeat (BIT_CYC) @(negedge sysclk);
`endif
      uart_rx = stop_bit;
      repeat (BIT_CYC) @(negedge sysclk);
      uart_rx = 1'b1;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 20 * BIT_CYC && sb_q.size() != 0; i++) @(negedge sysclk);
      check_eq("sb_drain", sb_q.size(), 0);
      repeat (2) @(negedge sysclk);
   endtask

   task automatic ack_pulse();
      @(negedge sysclk);
      rx_ack = 1'b1;
      @(negedge sysclk);
      rx_ack = 1'b0;
   endtask

   // Monitor: a commit is a rise of rx_valid or new data while valid.
   logic       mon_valid_q = 1'b0;
   logic [7:0] mon_data_q  = 8'h00;

   always @(negedge sysclk) begin
      if (!reset && rx_valid && (!mon_valid_q || rx_data != mon_data_q)) begin
         if (sb_q.size() == 0) begin
            check_eq("unexpected_commit", {24'd0, rx_data}, 32'h100);
         end else begin
            check_eq("rx_data", {24'd0, rx_data}, {24'd0, sb_q[0].data});
            check_eq("parity_err_at_commit", parity_err, sb_q[0].perr);
            void'(sb_q.pop_front());
         end
      end
      mon_valid_q <= rx_valid;
      mon_data_q  <= rx_data;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;

      repeat (5) @(negedge sysclk);
      check_eq("rst_rx_data", rx_data, 8'h00);
      check_eq("rst_rx_valid", rx_valid, 1'b0);
      check_eq("rst_frame_err", frame_err, 1'b0);
      check_eq("rst_overrun", overrun, 1'b0);
      check_eq("rst_parity_err", parity_err, 1'b0);
      reset = 1'b0;
      repeat (20) @(negedge sysclk);

      // Single byte with latency measurement
      push_exp(8'h55, 1'b0);
      lat = 0;
      fork
         send_frame(8'h55, 1'b1, 1'b0);
         begin
            wait (uart_rx == 1'b0);
            for (lat = 0; lat < 2000 && !rx_valid; lat++) @(negedge sysclk);
         end
      join
      wait_drain();
      check_eq("latency_window", (lat >= 600) && (lat <= 640), 1'b1);
      check_eq("b55_valid", rx_valid, 1'b1);
      check_eq("b55_frame_err", frame_err, 1'b0);
      check_eq("b55_overrun", overrun, 1'b0);
      ack_pulse();
      check_eq("b55_ack_valid", rx_valid, 1'b0);

      // Back-to-back bytes, no acknowledge
      push_exp(8'hA3, 1'b0);
      push_exp(8'h3C, 1'b0);
      send_frame(8'hA3, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b0);
      wait_drain();
      check_eq("b2b_data", rx_data, 8'h3C);
      check_eq("b2b_valid", rx_valid, 1'b1);
      check_eq("b2b_overrun", overrun, 1'b1);
      ack_pulse();
      check_eq("b2b_ack_valid", rx_valid, 1'b0);
      check_eq("b2b_ack_overrun", overrun, 1'b0);

      // Stop bit low
      send_frame(8'h81, 1'b0, 1'b0);
      repeat (BIT_CYC) @(negedge sysclk);
      check_eq("ferr_flag", frame_err, 1'b1);
      check_eq("ferr_valid", rx_valid, 1'b0);
      check_eq("ferr_data", rx_data, 8'h3C);
      push_exp(8'h12, 1'b0);
      send_frame(8'h12, 1'b1, 1'b0);
      wait_drain();
      check_eq("after_ferr_data", rx_data, 8'h12);
      check_eq("after_ferr_valid", rx_valid, 1'b1);
      check_eq("after_ferr_overrun", overrun, 1'b0);

      // Short low glitch on the idle line
      @(negedge sysclk);
      uart_rx = 1'b0;
      repeat (8) @(negedge sysclk);
      uart_rx = 1'b1;
      repeat (3 * BIT_CYC) @(negedge sysclk);
      check_eq("glitch_data", rx_data, 8'h12);
      check_eq("glitch_valid", rx_valid, 1'b1);
      check_eq("glitch_frame_err", frame_err, 1'b1);
      check_eq("glitch_overrun", overrun, 1'b0);

      // Reset during data bit 4 of 0xFF
      fork
         send_frame(8'hFF, 1'b1, 1'b0);
         begin
            repeat (5 * BIT_CYC + BIT_CYC / 2) @(negedge sysclk);
            reset = 1'b1;
            #1;
            check_eq("midrst_data", rx_data, 8'h00);
            check_eq("midrst_valid", rx_valid, 1'b0);
            check_eq("midrst_frame_err", frame_err, 1'b0);
            check_eq("midrst_overrun", overrun, 1'b0);
            check_eq("midrst_parity_err", parity_err, 1'b0);
            repeat (3) @(negedge sysclk);
            reset = 1'b0;
         end
      join
      repeat (2 * BIT_CYC) @(negedge sysclk);
      check_eq("post_rst_valid", rx_valid, 1'b0);
      push_exp(8'h0F, 1'b0);
      send_frame(8'h0F, 1'b1, 1'b0);
      wait_drain();
      check_eq("b0f_data", rx_data, 8'h0F);
      check_eq("b0f_valid", rx_valid, 1'b1);
      check_eq("b0f_frame_err", frame_err, 1'b0);

`ifdef UART_RX_PARITY_EN
      ack_pulse();
      push_exp(8'h07, 1'b1);
      send_frame(8'h07, 1'b1, 1'b1);
      wait_drain();
      check_eq("par_bad_valid", rx_valid, 1'b1);
      check_eq("par_bad_flag", parity_err, 1'b1);
      ack_pulse();
      check_eq("par_ack_flag", parity_err, 1'b0);
      push_exp(8'h07, 1'b0);
      send_frame(8'h07, 1'b1, 1'b0);
      wait_drain();
      check_eq("par_good_data", rx_data, 8'h07);
      check_eq("par_good_flag", parity_err, 1'b0);
`else
      check_eq("parity_tied_low", parity_err, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
